ser_ctrl: RTL and testbench

Sequencer for the 8b/10b serializer path (input latch -> encoder -> 10-bit PISO). It takes bytes from a valid/ready source and buffers one byte. It issues one byte per 10-bit symbol slot on data_en/parallel_data_out, and fires load_en into the PISO a fixed pipeline delay later. When no byte is available it fills the slot with an idle byte, so the line never starves.

---
 rtl/ser_ctrl.sv | 105 ++++++++++
 tb/tb_ser_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ser_ctrl.sv
`timescale 1ns/1ps
// ser_ctrl: slot sequencer for the 8b/10b serializer path. Buffers one source
// byte, issues one byte (or an idle filler) per symbol slot, and strobes the PISO load.
module ser_ctrl #(
   parameter int          SYM_BITS  = 10,
   parameter int          PIPE_LAT  = 2,
   parameter logic [7:0]  IDLE_BYTE = 8'hBC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        data_en,
   output logic [7:0]  parallel_data_out,
   output logic        load_en,
   output logic        busy,
   output logic [7:0]  underrun_cnt
);

   localparam int                CNT_W    = $clog2(SYM_BITS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SYM_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic                 buf_full;
   logic [7:0]           buf_data;
   logic [PIPE_LAT-1:0]  dly;
   logic [7:0]           pdo_q;
   logic                 issue_now;
   logic                 slot_end;
   logic                 accept;
   logic [7:0]           issue_byte;

   assign issue_now  = (state == S_RUN) && (cnt == '0);
   assign slot_end   = (cnt == CNT_LAST);
   assign s_ready    = !buf_full || issue_now;
   assign accept     = s_valid && s_ready;
   assign issue_byte = buf_full ? buf_data : IDLE_BYTE;

   assign data_en           = issue_now;
   assign parallel_data_out = issue_now ? issue_byte : pdo_q;
   assign load_en           = dly[PIPE_LAT-1];
   assign busy              = (state != S_IDLE);

   // Leaving DRAIN waits for an empty delay line so the last symbol is loaded
   // and has a full slot to shift out before the line goes quiet.
   always_comb begin
      // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
      state_nxt = state;
      case (state)
         S_IDLE:  if (enable) state_nxt = S_RUN;
         S_RUN:   if (slot_end && !enable) state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (slot_end) begin
               if (enable)        state_nxt = S_RUN;
               else if (dly == '0) state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         buf_full     <= 1'b0;
         buf_data     <= 8'h00;
         dly          <= '0;
         pdo_q        <= 8'h00;
         underrun_cnt <= 8'h00;
      end else begin
         state <= state_nxt;

         if (state == S_IDLE) cnt <= '0;
         else                 cnt <= slot_end ? '0 : cnt + 1'b1;

         // A byte accepted in the issue cycle lands in the buffer for the next slot.
         if (accept) begin
            buf_full <= 1'b1;
            buf_data <= s_data;
         end else if (issue_now) begin
            buf_full <= 1'b0;
         end

         if (issue_now) pdo_q <= issue_byte;

         if (issue_now && !buf_full && (underrun_cnt != 8'hFF))
            underrun_cnt <= underrun_cnt + 8'h01;

         dly <= (dly << 1) | PIPE_LAT'(issue_now);
      end
   end

endmodule

// File: tb/tb_ser_ctrl.sv
`timescale 1ns/1ps
// tb_ser_ctrl: directed stimulus for ser_ctrl; expected bytes and load times
// are queued by the stimulus and consumed by an independent negedge monitor.
module tb_ser_ctrl;

   localparam int          SYM_BITS  = 10;
   localparam int          PIPE_LAT  = 2;
   localparam logic [7:0]  IDLE_BYTE = 8'hBC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        data_en;
   logic [7:0]  parallel_data_out;
   logic        load_en;
   logic        busy;
   logic [7:0]  underrun_cnt;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          last_de  = -1;
   bit          cont     = 1'b0;
   int          le_seen  = 0;
   logic [7:0]  exp_q[$];
   int          lq[$];

   ser_ctrl #(
      .SYM_BITS  (SYM_BITS),
      .PIPE_LAT  (PIPE_LAT),
      .IDLE_BYTE (IDLE_BYTE)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enable            (enable),
      .s_valid           (s_valid),
      .s_data            (s_data),
      .s_ready           (s_ready),
      .data_en           (data_en),
      .parallel_data_out (parallel_data_out),
      .load_en           (load_en),
      .busy              (busy),
      .underrun_cnt      (underrun_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the next queued byte and slot spacing;
   // every load_en must land exactly PIPE_LAT cycles after its data_en.
   always @(negedge clk) begin
      if (data_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_data_en: got byte %0h expected no strobe (cycle %0d)",
                     parallel_data_out, cyc);
         end else begin
            check("issue_byte", parallel_data_out, exp_q.pop_front());
         end
         if (cont && last_de >= 0) check("de_period", cyc - last_de, SYM_BITS);
         last_de = cyc;
         lq.push_back(cyc + PIPE_LAT);
      end
      if (load_en) begin
         le_seen++;
         if (lq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_load_en: got strobe expected none (cycle %0d)", cyc);
         end else begin
            check("load_delay", cyc, lq.pop_front());
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      exp_q.push_back(b);
      s_valid = 1'b1;
      s_data  = b;
      while (!s_ready && n < 3 * SYM_BITS) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", s_ready, 1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_de();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!data_en && n < 3 * SYM_BITS);
      check("de_seen", data_en, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 4 * SYM_BITS) begin
         @(negedge clk);
         n++;
      end
      check("busy_fall", busy, 0);
   endtask

   initial begin
      int le_mark;
      rst_n   = 1'b0;
      enable  = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data_en", data_en, 0);
      check("rst_load_en", load_en, 0);
      check("rst_busy", busy, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_pdo", parallel_data_out, 8'h00);
      check("rst_underrun", underrun_cnt, 0);
      rst_n = 1'b1;

      // Back-to-back stream 01..08, then graceful stop at cnt==3 of the last slot
      @(negedge clk);
      last_de = -1;
      cont    = 1'b1;
      enable  = 1'b1;
      for (int i = 1; i <= 8; i++) send(8'(i));
      wait_de();
      repeat (3) @(negedge clk);
      enable = 1'b0;
      repeat (16) @(negedge clk);
      check("drain_busy", busy, 1);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("stream_underrun", underrun_cnt, 0);
      check("idle_s_ready", s_ready, 1);

      // Underrun x3, then 5A, then A1 with A2 offered at the A1 issue cycle
      repeat (2) @(negedge clk);
      last_de = -1;
      for (int i = 0; i < 3; i++) exp_q.push_back(IDLE_BYTE);
      enable = 1'b1;
      @(negedge clk);
      check("restart_de", data_en, 1);
      wait_de();
      wait_de();
      @(negedge clk);
      check("underrun3", underrun_cnt, 3);
      send(8'h5A);
      send(8'hA1);
      exp_q.push_back(8'hA2);
      s_valid = 1'b1;
      s_data  = 8'hA2;
      check("a2_blocked", s_ready, 0);
      repeat (9) @(negedge clk);
      check("a1_issue_de", data_en, 1);
      check("a1_issue_ready", s_ready, 1);
      check("a1_issue_byte", parallel_data_out, 8'hA1);
      @(negedge clk);
      s_valid = 1'b0;
      check("a2_buffered", s_ready, 0);
      check("pdo_hold", parallel_data_out, 8'hA1);
      wait_de();
      enable = 1'b0;
      wait_idle();
      check("underrun_after_c", underrun_cnt, 3);

      // Reset mid-RUN with the buffer full and a load_en in flight
      @(negedge clk);
      last_de = -1;
      cont    = 1'b0;
      enable  = 1'b1;
      send(8'hC1);
      send(8'hC2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_data_en", data_en, 0);
      check("mid_rst_load_en", load_en, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_s_ready", s_ready, 1);
      check("mid_rst_underrun", underrun_cnt, 0);
      check("mid_rst_pdo", parallel_data_out, 8'h00);
      exp_q.delete();
      lq.delete();
      le_mark = le_seen;
      enable  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3 * SYM_BITS) @(negedge clk);
      check("no_load_after_rst", le_seen, le_mark);
      check("post_rst_busy", busy, 0);

      // Saturation: 300 consecutive underrun slots
      last_de = -1;
      cont    = 1'b1;
      for (int i = 0; i < 300; i++) exp_q.push_back(IDLE_BYTE);
      enable = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         wait_de();
         if (i == 254 || i == 255 || i == 300) begin
            @(negedge clk);
            check("sat_count", underrun_cnt, (i > 255) ? 255 : i);
         end
      end
      enable = 1'b0;
      wait_idle();
      check("sat_final", underrun_cnt, 255);
      cont = 1'b0;

      repeat (3) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      check("load_q_drained", lq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
